// File: rtl/slc_core_pkg.sv
// Shared types for the slc_core processor: opcodes, FSM states, condition codes.
// The configuration macro SLC_CORE_ILLEGAL_HALT_EN is consumed in rtl/slc_core.sv.
package slc_core_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_JMP = 4'b1100,
    OP_PSE = 4'b1101
  } opcode_t;

  typedef enum logic [3:0] {
    S_HALTED,
    S_F1,
    S_F2,
    S_F3,
    S_DECODE,
    S_EXEC,
    S_BR,
    S_JMP,
    S_LD_ADDR,
    S_LD_MEM,
    S_LD_WB,
    S_ST_ADDR,
    S_ST_MEM,
    S_PAUSE
  } state_t;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  localparam int NUM_REGS = 8;

  // Exactly one of N/Z/P is ever set.
  function automatic logic [2:0] cc_from(input logic neg, input logic zero);
    if (zero) begin
      return CC_Z;
    end else if (neg) begin
      return CC_N;
    end else begin
      return CC_P;
    end
  endfunction

endpackage

// File: rtl/slc_core_if.sv
// Memory bus between slc_core (master) and its memory (slave).
// Handshake: a request is valid while mem_mem_ena is high; mem_addr, mem_wr_ena and
// mem_wdata are held stable until the cycle mem_ready_i is sampled high, which completes it.
interface slc_core_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_mem_ena;
    logic              mem_wr_ena;

    modport master (
        output mem_wdata, mem_addr, mem_mem_ena, mem_wr_ena,
        input  mem_rdata, mem_ready_i
    );

    modport slave (
        input  mem_wdata, mem_addr, mem_mem_ena, mem_wr_ena,
        output mem_rdata, mem_ready_i
    );

endinterface

// File: rtl/slc_regfile.sv
// Eight general registers: two combinational read ports, one synchronous write port.
// Reads return the pre-write value, so a same-register source/destination is safe.
module slc_regfile
    import slc_core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/slc_core.sv
// Multi-cycle LC-3 style core: fetch/decode/execute FSM, register file, memory bus master.
// Define SLC_CORE_ILLEGAL_HALT_EN to halt on undefined opcodes; otherwise they act as NOPs.
module slc_core
    import slc_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              continue_i,
    slc_core_if.master        mem,
    output logic [15:0]       hex_display_debug,
    output logic [15:0]       led_o,
    output state_t            dbg_state,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [2:0]        dbg_cc
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [15:0]       ir;
    logic [2:0]        cc;
    logic [15:0]       led;
    logic              mem_ena;
    logic              wr_ena;
    logic              addr_setup;

    opcode_t           op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] imm5;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] alu;
    logic [2:0]        rf_raddr_b;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        cc_next;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] off6;
    logic [ADDR_W-1:0] eff_addr;
    logic [ADDR_W-1:0] br_off;

    assign op = opcode_t'(ir[15:12]);

    // Port B serves SR2 for ALU ops and the source register for stores.
    assign rf_raddr_b = (op == OP_STR) ? ir[11:9] : ir[2:0];

    slc_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (ir[11:9]),
        .wdata   (rf_wdata),
        .raddr_a (ir[8:6]),
        .raddr_b (rf_raddr_b),
        .rdata_a (src_a),
        .rdata_b (src_b)
    );

    assign imm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign op2  = ir[5] ? imm5 : src_b;

    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = src_a + op2;
            OP_AND:  alu = src_a & op2;
            OP_NOT:  alu = ~src_a;
            default: alu = '0;
        endcase
    end

    assign rf_we    = (state == S_EXEC) || (state == S_LD_WB);
    assign rf_wdata = (state == S_LD_WB) ? mdr : alu;
    assign cc_next  = cc_from(rf_wdata[DATA_W-1], rf_wdata == '0);

    // Register values become addresses by truncation or zero-extension.
    if (DATA_W >= ADDR_W) begin : g_base_trunc
        assign base_addr = src_a[ADDR_W-1:0];
    end else begin : g_base_zext
        assign base_addr = {{(ADDR_W-DATA_W){1'b0}}, src_a};
    end

    if (ADDR_W > 9) begin : g_br_sext
        assign br_off = {{(ADDR_W-9){ir[8]}}, ir[8:0]};
    end else begin : g_br_trunc
        assign br_off = ir[ADDR_W-1:0];
    end

    assign off6     = {{(ADDR_W-6){ir[5]}}, ir[5:0]};
    assign eff_addr = base_addr + off6;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_HALTED;
            pc         <= '0;
            mar        <= '0;
            mdr        <= '0;
            ir         <= '0;
            cc         <= '0;
            led        <= '0;
            mem_ena    <= 1'b0;
            wr_ena     <= 1'b0;
            addr_setup <= 1'b0;
        end else begin
            case (state)
                S_HALTED: begin
                    if (run_i) state <= S_F1;
                end
                S_F1: begin
                    mar     <= pc;
                    pc      <= pc + 1'b1;
                    mem_ena <= 1'b1;
                    wr_ena  <= 1'b0;
                    state   <= S_F2;
                end
                S_F2: begin
                    if (mem.mem_ready_i) begin
                        mdr     <= mem.mem_rdata;
                        mem_ena <= 1'b0;
                        state   <= S_F3;
                    end
                end
                S_F3: begin
                    ir    <= mdr[15:0];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: state <= S_EXEC;
                        OP_BR:  state <= S_BR;
                        OP_JMP: state <= S_JMP;
                        OP_LDR: state <= S_LD_ADDR;
                        OP_STR: state <= S_ST_ADDR;
                        OP_PSE: begin
                            led   <= {4'b0000, ir[11:0]};
                            state <= S_PAUSE;
                        end
                        default: begin
`ifdef SLC_CORE_ILLEGAL_HALT_EN
                            led   <= 16'hDEAD;
                            state <= S_HALTED;
`else
                            state <= S_F1;
`endif
                        end
                    endcase
                end
                S_EXEC: begin
                    cc    <= cc_next;
                    state <= S_F1;
                end
                S_BR: begin
                    if ((ir[11:9] & cc) != 3'b000) pc <= pc + br_off;
                    state <= S_F1;
                end
                S_JMP: begin
                    pc    <= base_addr;
                    state <= S_F1;
                end
                // Data accesses spend two cycles here: the computed address lands in MAR,
                // then is presented for a full cycle before the strobe is raised.
                S_LD_ADDR: begin
                    if (!addr_setup) begin
                        mar        <= eff_addr;
                        addr_setup <= 1'b1;
                    end else begin
                        addr_setup <= 1'b0;
                        mem_ena    <= 1'b1;
                        state      <= S_LD_MEM;
                    end
                end
                S_LD_MEM: begin
                    if (mem.mem_ready_i) begin
                        mdr     <= mem.mem_rdata;
                        mem_ena <= 1'b0;
                        state   <= S_LD_WB;
                    end
                end
                S_LD_WB: begin
                    cc    <= cc_next;
                    state <= S_F1;
                end
                S_ST_ADDR: begin
                    if (!addr_setup) begin
                        mar        <= eff_addr;
                        mdr        <= src_b;
                        addr_setup <= 1'b1;
                    end else begin
                        addr_setup <= 1'b0;
                        mem_ena    <= 1'b1;
                        wr_ena     <= 1'b1;
                        state      <= S_ST_MEM;
                    end
                end
                S_ST_MEM: begin
                    if (mem.mem_ready_i) begin
                        mem_ena <= 1'b0;
                        wr_ena  <= 1'b0;
                        state   <= S_F1;
                    end
                end
                S_PAUSE: begin
                    if (continue_i) state <= S_F1;
                end
                default: state <= S_HALTED;
            endcase
        end
    end

    assign mem.mem_wdata   = mdr;
    assign mem.mem_addr    = mar;
    assign mem.mem_mem_ena = mem_ena;
    assign mem.mem_wr_ena  = wr_ena;

    assign hex_display_debug = ir;
    assign led_o             = led;
    assign dbg_state         = state;
    assign dbg_pc            = pc;
    assign dbg_cc            = cc;

endmodule

// File: doc/slc_core.md
SLC_CORE -- requirements
Module: slc_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath/register/memory-data width (legal 16..32).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning memory address width (legal 8..32).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports run_i  input  1  start from HALTED; continue_i  input  1  resume from PAUSE.
REQ-006 SHALL have ports mem_rdata  input  DATA_W  read data; mem_ready_i  input  1  access-complete strobe.
REQ-007 SHALL have ports mem_wdata  output  DATA_W (=MDR); mem_addr  output  ADDR_W (=MAR low bits); mem_mem_ena  output  1; mem_wr_ena  output  1.
REQ-008 SHALL have ports hex_display_debug  output  16  (=IR); led_o  output  16  pause code.

Function
REQ-009 SHALL implement FSM states HALTED, F1, F2, F3, DECODE, EXEC, BR, JMP, LD_ADDR, LD_MEM, LD_WB, ST_ADDR, ST_MEM, PAUSE.
REQ-010 SHALL leave HALTED for F1 when run_i sampled high; run_i in any other state ignored.
REQ-011 F1: MAR<=PC, PC<=PC+1 (mod 2^ADDR_W, wraps to 0); -> F2.
REQ-012 F2/LD_MEM: mem_mem_ena=1, mem_wr_ena=0, held until mem_ready_i high; MDR<=mem_rdata in ready cycle, then advance.
REQ-013 ST_MEM: mem_mem_ena=1, mem_wr_ena=1, MAR/MDR stable, held until mem_ready_i high, then -> F1.
REQ-014 mem_mem_ena, mem_wr_ena SHALL be 0 in every other state.
REQ-015 F3: IR<=MDR[15:0]; DECODE dispatches on IR[15:12]: 0001 ADD, 0101 AND, 1001 NOT -> EXEC; 0000 BR; 1100 JMP; 0110 LDR; 0111 STR; 1101 PSE -> PAUSE.
REQ-016 ADD/AND: DR=IR[11:9], SR1=IR[8:6]; operand2 = IR[5] ? sext(IR[4:0]) to DATA_W : R[IR[2:0]]; NOT: DR<=~SR1; result mod 2^DATA_W.
REQ-017 CC (N,Z,P) SHALL update on ADD/AND/NOT/LDR writeback: N=msb of DATA_W result, Z=result==0, P otherwise; exactly one bit set.
REQ-018 BR: if (IR[11:9] & CC)!=0 then PC<=PC+sext(IR[8:0]) with wrap; else PC unchanged; -> F1.
REQ-019 JMP: PC<=R[IR[8:6]][ADDR_W-1:0] (zero-extend if DATA_W<ADDR_W); -> F1.
REQ-020 LDR: MAR<=R[IR[8:6]]+sext(IR[5:0]); LD_MEM read; LD_WB R[IR[11:9]]<=MDR, CC set.
REQ-021 STR: ST_ADDR MAR<=base+sext(IR[5:0]), MDR<=R[IR[11:9]]; ST_MEM write.
REQ-022 PAUSE: led_o<={4'b0,IR[11:0]}; -> F1 in cycle continue_i sampled high; led_o holds until next PSE or reset.
REQ-023 Zero-wait memory (mem_ready_i tied 1): ADD/AND/NOT/BR/JMP retire in 5 cycles, LDR 8, STR 7; each low ready cycle adds one.
REQ-024 Same-register source/destination (e.g. ADD R1,R1,R1) SHALL read pre-write value.

Reset
REQ-025 On reset: state HALTED, PC=0, MAR=0, MDR=0, IR=0, R0..R7=0, CC=000, led_o=0, mem_mem_ena=0, mem_wr_ena=0, next cycle.
REQ-026 Reset mid-access SHALL drop mem_mem_ena/mem_wr_ena the following cycle; no writeback of in-flight data.

Configuration
REQ-027 Macro SLC_CORE_ILLEGAL_HALT_EN defined: undefined opcodes -> HALTED, led_o<=16'hDEAD; undefined: undefined opcodes act as NOP (DECODE -> F1, no state change).

Structure
REQ-028 Package slc_core_pkg SHALL hold opcode enum, FSM state enum, CC bit constants.
REQ-029 Sub-module slc_regfile SHALL hold 8 x DATA_W registers, 2 async read ports, 1 sync write port, synchronous reset.

Verification
REQ-030 DATA_W=16, ready=1, mem[0]=0x1261 (ADD R1,R1,#1), run_i pulse -> R1=1, CC=001, PC=1, F1 re-entered 5 cycles after first F1.
REQ-031 mem[0]=0x5020 (AND R0,R0,#0), mem[1]=0x0401 (BRz +1) -> PC=3 after BR; with R0 forced nonzero via ADD first, PC=2.
REQ-032 mem_ready_i low 3 cycles during fetch -> mem_mem_ena high 4 cycles, mem_addr stable, retire +3 cycles.
REQ-033 STR R2,R3,#-1 with R3=0x0010, R2=0xBEEF -> write at addr 0x000F, wdata 0xBEEF, mem_wr_ena high until ready.
REQ-034 DATA_W=32: NOT of 0 -> 0xFFFFFFFF, CC=100; PSE 0xD0A5 -> led_o=0x00A5, stalls until continue_i.
REQ-035 PC=0xFFFF fetch -> PC wraps to 0x0000; reset asserted in F2 -> mem_mem_ena 0 next cycle, state HALTED.
